// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: turns one TxStart/TxData request into a framed
// serial character (start, 5-8 data bits LSB first, optional parity, 1-2 stop)
// with an internal baud counter and a one-cycle TxDone on the final stop cycle.
module uart_tx_serializer #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             pClk,
    input  logic             pReset,
    input  logic             TxStart,
    input  logic [7:0]       TxData,
    input  logic [DIV_W-1:0] BaudDiv,
    input  logic [1:0]       DataLen,
    input  logic             StopBits,
    input  logic             ParityEn,
    input  logic             EvenParity,
    output logic             TxSerial,
    output logic             TxBusy,
    output logic             TxDone
);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop1,
        StStop2
    } state_t;

    state_t           r_state;
    logic [DIV_W-1:0] r_baud_cnt;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic             r_parity;

    // Frame configuration captured at acceptance; frozen for the whole frame
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_len;
    logic             r_stop2;
    logic             r_par_en;
    logic             r_even;

    logic             r_tx;
    logic             r_busy;
    logic             r_done;

    logic             w_accept;
    logic             w_bit_end;
    logic             w_next_is_last;
    logic             w_div_zero;
    logic             w_last_data;
    logic [2:0]       w_nbits_m1;
    logic [7:0]       w_shift_src;

    // r_done is high only in the last cycle of the final stop bit, which is
    // exactly the back-to-back acceptance window.
    assign w_accept       = TxStart && ((r_state == StIdle) || r_done);
    assign w_bit_end      = (r_baud_cnt == r_div);
    assign w_next_is_last = ((r_baud_cnt + DIV_W'(1)) == r_div);
    assign w_div_zero     = (r_div == '0);
    assign w_nbits_m1     = {1'b0, r_len} + 3'd4;
    assign w_last_data    = (r_bit_cnt == w_nbits_m1);
    // With BaudDiv=0 the start bit ends on the same edge TxData is captured,
    // so the first data bit must come straight from the input.
    assign w_shift_src    = (r_baud_cnt == '0) ? TxData : r_shift;

    // Frame FSM; outputs are registered and set for the cycle being entered
    always_ff @(posedge pClk) begin
        if (pReset) begin
            r_state    <= StIdle;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_div      <= '0;
            r_len      <= '0;
            r_stop2    <= 1'b0;
            r_par_en   <= 1'b0;
            r_even     <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_div      <= BaudDiv;
                r_len      <= DataLen;
                r_stop2    <= StopBits;
                r_par_en   <= ParityEn;
                r_even     <= EvenParity;
                r_state    <= StStart;
                r_baud_cnt <= '0;
                r_bit_cnt  <= '0;
                r_parity   <= 1'b0;
                r_tx       <= 1'b0;
                r_busy     <= 1'b1;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        r_tx   <= 1'b1;
                        r_busy <= 1'b0;
                    end
                    StStart: begin
                        // TxData becomes valid the cycle after TxStart
                        if (r_baud_cnt == '0) begin
                            r_shift <= TxData;
                        end
                        if (w_bit_end) begin
                            r_state    <= StData;
                            r_baud_cnt <= '0;
                            r_tx       <= w_shift_src[0];
                        end else begin
                            r_baud_cnt <= r_baud_cnt + DIV_W'(1);
                        end
                    end
                    StData: begin
                        if (w_bit_end) begin
                            r_baud_cnt <= '0;
                            r_parity   <= r_parity ^ r_shift[0];
                            r_shift    <= r_shift >> 1;
                            if (!w_last_data) begin
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                                r_tx      <= r_shift[1];
                            end else if (r_par_en) begin
                                r_state <= StParity;
                                r_tx    <= r_parity ^ r_shift[0] ^ ~r_even;
                            end else begin
                                r_state <= StStop1;
                                r_tx    <= 1'b1;
                                r_done  <= !r_stop2 && w_div_zero;
                            end
                        end else begin
                            r_baud_cnt <= r_baud_cnt + DIV_W'(1);
                        end
                    end
                    StParity: begin
                        if (w_bit_end) begin
                            r_state    <= StStop1;
                            r_baud_cnt <= '0;
                            r_tx       <= 1'b1;
                            r_done     <= !r_stop2 && w_div_zero;
                        end else begin
                            r_baud_cnt <= r_baud_cnt + DIV_W'(1);
                        end
                    end
                    StStop1: begin
                        if (w_bit_end) begin
                            r_baud_cnt <= '0;
                            if (r_stop2) begin
                                r_state <= StStop2;
                                r_done  <= w_div_zero;
                            end else begin
                                r_state <= StIdle;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_baud_cnt <= r_baud_cnt + DIV_W'(1);
                            r_done     <= !r_stop2 && w_next_is_last;
                        end
                    end
                    StStop2: begin
                        if (w_bit_end) begin
                            r_baud_cnt <= '0;
                            r_state    <= StIdle;
                            r_busy     <= 1'b0;
                        end else begin
                            r_baud_cnt <= r_baud_cnt + DIV_W'(1);
                            r_done     <= w_next_is_last;
                        end
                    end
                    default: begin
                        r_state <= StIdle;
                        r_tx    <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign TxSerial = r_tx;
    assign TxBusy   = r_busy;
    assign TxDone   = r_done;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: stimulus pushes the expected frame
// waveform when a TxStart should be accepted; a negedge monitor pops and
// compares line/busy/done cycle by cycle.
module tb_uart_tx_serializer;

    localparam int DIV_W = 16;

    logic             pClk = 1'b0;
    logic             pReset = 1'b1;
    logic             TxStart = 1'b0;
    logic [7:0]       TxData = 8'h00;
    logic [DIV_W-1:0] BaudDiv = '0;
    logic [1:0]       DataLen = 2'd0;
    logic             StopBits = 1'b0;
    logic             ParityEn = 1'b0;
    logic             EvenParity = 1'b0;
    logic             TxSerial;
    logic             TxBusy;
    logic             TxDone;

    uart_tx_serializer #(.DIV_W(DIV_W)) dut (
        .pClk       (pClk),
        .pReset     (pReset),
        .TxStart    (TxStart),
        .TxData     (TxData),
        .BaudDiv    (BaudDiv),
        .DataLen    (DataLen),
        .StopBits   (StopBits),
        .ParityEn   (ParityEn),
        .EvenParity (EvenParity),
        .TxSerial   (TxSerial),
        .TxBusy     (TxBusy),
        .TxDone     (TxDone)
    );

    always #5 pClk = ~pClk;

    int   cyc = 0;
    logic rst_q = 1'b0;
    always @(posedge pClk) begin
        cyc   <= cyc + 1;
        rst_q <= pReset;
    end

    typedef struct {
        logic [11:0] bits;
        int          nbits;
        int          per;
        int          acc;
    } frame_t;

    frame_t exp_q[$];
    int     n_checks = 0;
    int     n_pass = 0;
    int     model_end = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, req);
    endtask

    // Reference frame: list of line levels, one per bit period
    function automatic frame_t build(input logic [7:0] d, input int div, input int len,
                                     input bit stop2, input bit par, input bit even,
                                     input int acc);
        frame_t f;
        int     n;
        int     k;
        bit     p;
        n = len + 5;
        f.bits = '1;
        f.bits[0] = 1'b0;
        p = 1'b0;
        for (int i = 0; i < n; i++) begin
            f.bits[1 + i] = d[i];
            p ^= d[i];
        end
        k = 1 + n;
        if (par) begin
            f.bits[k] = even ? p : !p;
            k++;
        end
        f.nbits = k + 1 + int'(stop2);
        f.per = div + 1;
        f.acc = acc;
        return f;
    endfunction

    // Monitor
    bit     in_frame = 1'b0;
    frame_t cur;
    int     pos = 0;
    int     total = 0;
    always @(negedge pClk) begin
        if (rst_q) begin
            check("reset_idle", 32'({TxSerial, TxBusy, TxDone}), 32'(3'b100));
            exp_q.delete();
            in_frame = 1'b0;
        end else if (!in_frame) begin
            if (TxSerial === 1'b0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 32'({TxSerial, TxBusy}), 32'(2'b10));
                end else begin
                    cur = exp_q.pop_front();
                    in_frame = 1'b1;
                    pos = 0;
                    check("frame_latency", cyc, cur.acc + 1);
                end
            end else begin
                check("idle_line", 32'({TxSerial, TxBusy, TxDone}), 32'(3'b100));
            end
        end
        if (in_frame && !rst_q) begin
            total = cur.nbits * cur.per;
            check("frame_cycle", 32'({TxSerial, TxBusy, TxDone}),
                  32'({cur.bits[pos / cur.per], 1'b1, pos == total - 1}));
            pos++;
            if (pos == total) in_frame = 1'b0;
        end
    end

    task automatic tick();
        @(posedge pClk);
        #1;
    endtask

    task automatic scramble_cfg();
        BaudDiv    = DIV_W'($urandom);
        DataLen    = 2'($urandom);
        StopBits   = 1'($urandom);
        ParityEn   = 1'($urandom);
        EvenParity = 1'($urandom);
    endtask

    // Issue TxStart now; expected frame pushed only if the model accepts it
    task automatic start_frame(input logic [7:0] d, input int div, input int len,
                               input bit stop2, input bit par, input bit even);
        frame_t f;
        TxStart    = 1'b1;
        TxData     = 8'($urandom);
        BaudDiv    = DIV_W'(div);
        DataLen    = 2'(len);
        StopBits   = stop2;
        ParityEn   = par;
        EvenParity = even;
        if (!pReset && cyc >= model_end) begin
            f = build(d, div, len, stop2, par, even, cyc);
            exp_q.push_back(f);
            model_end = cyc + f.nbits * f.per;
        end
        tick();
        TxStart = 1'b0;
        TxData  = d;
        scramble_cfg();
        tick();
        TxData = 8'($urandom);
    endtask

    task automatic wait_idle();
        while (cyc <= model_end) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL timeout cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    int c0;
    int mode;

    initial begin
        // Reset hold with TxStart pulsing
        for (int i = 0; i < 5; i++) begin
            TxStart = i[0];
            TxData  = 8'($urandom);
            tick();
        end
        TxStart = 1'b0;
        pReset  = 1'b0;
        model_end = 0;
        repeat (4) tick();

        // 8N1, slow baud
        start_frame(8'h55, 3, 3, 1'b0, 1'b0, 1'b0);
        wait_idle();
        // 7 bits with even, then odd parity
        start_frame(8'hB5, 0, 2, 1'b0, 1'b1, 1'b1);
        wait_idle();
        start_frame(8'hB5, 0, 2, 1'b0, 1'b1, 1'b0);
        wait_idle();
        // 5 bits, two stop bits
        start_frame(8'h1F, 1, 0, 1'b1, 1'b0, 1'b0);
        wait_idle();
        tick();

        // Mid-frame start ignored, then back-to-back on TxDone
        start_frame(8'h0F, 1, 3, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        start_frame(8'hAA, 0, 1, 1'b1, 1'b1, 1'b1);
        while (cyc < model_end) tick();
        start_frame(8'hF0, 1, 3, 1'b0, 1'b0, 1'b0);
        wait_idle();
        tick();

        // Reset during data bit 3, then a clean frame
        c0 = cyc;
        start_frame(8'hA5, 2, 3, 1'b0, 1'b1, 1'b1);
        while (cyc < c0 + 14) tick();
        pReset = 1'b1;
        model_end = 0;
        tick();
        pReset = 1'b0;
        tick();
        tick();
        start_frame(8'h3C, 1, 3, 1'b1, 1'b1, 1'b0);
        wait_idle();

        // Randomized traffic: back-to-back, gaps, and mid-frame attempts
        for (int k = 0; k < 30; k++) begin
            mode = int'($urandom_range(0, 2));
            if (mode == 0) begin
                while (cyc < model_end) tick();
            end else if (mode == 1) begin
                wait_idle();
                repeat ($urandom_range(0, 3)) tick();
            end else begin
                repeat ($urandom_range(0, 5)) tick();
            end
            start_frame(8'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                        1'($urandom), 1'($urandom), 1'($urandom));
        end
        wait_idle();
        repeat (3) tick();

        check("queue_drained", exp_q.size(), 0);
        check("line_idle_end", 32'({TxSerial, TxBusy, TxDone}), 32'(3'b100));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
